shared_adder_arbiter: RTL and testbench

SHARED_ADDER_ARBITER -- requirements
Module: shared_adder_arbiter

---
 rtl/shared_adder_arbiter.sv | 145 ++++++++++++++
 tb/tb_shared_adder_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_adder_arbiter
// Description : Round-robin arbiter sharing one external adder between two
//               requesters, with a settle delay before the sum is captured.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_adder_arbiter #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             sel,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam logic [3:0] c_CNT_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic             r_last;
    logic             r_sel;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    logic             w_win;
    logic             w_start;
    logic             w_capture;
    logic             w_finish;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        w_win       = (req0 && req1) ? ~r_last : req1;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_last   <= 1'b1;
            r_sel    <= 1'b0;
            r_add_a  <= '0;
            r_add_b  <= '0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_sel   <= w_win;
                r_gnt0  <= ~w_win;
                r_gnt1  <= w_win;
                r_add_a <= w_win ? a1 : a0;
                r_add_b <= w_win ? b1 : b0;
                r_cnt   <= 4'd0;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // r_sel still identifies the winner while the transaction is live.
            if (w_capture) begin
                r_result <= add_sum;
                r_cout   <= add_cout;
                r_done0  <= ~r_sel;
                r_done1  <= r_sel;
            end
            if (w_finish) begin
                r_done0 <= 1'b0;
                r_done1 <= 1'b0;
                r_gnt0  <= 1'b0;
                r_gnt1  <= 1'b0;
                r_last  <= r_sel;
            end
        end
    end

    assign sel    = r_sel;
    assign add_a  = r_add_a;
    assign add_b  = r_add_b;
    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign done0  = r_done0;
    assign done1  = r_done1;
    assign result = r_result;
    assign cout   = r_cout;
    assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_adder_arbiter
// Description : Directed bench for shared_adder_arbiter with an ideal adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_adder_arbiter;

    localparam int WIDTH = 4;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             req0  = 1'b0;
    logic             req1  = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             sel;
    logic [WIDTH-1:0] add_a, add_b, add_sum, result;
    logic             add_cout, gnt0, gnt1, done0, done1, cout, busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    shared_adder_arbiter #(.WIDTH(WIDTH), .SETTLE(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .sel(sel), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_cout(add_cout),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .cout(cout), .busy(busy)
    );

    // Ideal combinational adder on the shared operand bus.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_w;

        // Reset for two cycles
        step();
        step();
        check("rst_ctrl", {25'd0, gnt1, gnt0, done1, done0, sel, busy, cout}, 32'd0);
        check("rst_add_a", {28'd0, add_a}, 32'd0);
        check("rst_add_b", {28'd0, add_b}, 32'd0);
        check("rst_result", {28'd0, result}, 32'd0);

        // Single requester 0: 5 + 3
        Reset = 1'b0; req0 = 1'b1; a0 = 4'd5; b0 = 4'd3;
        step();
        check("r0_c1_gnt", {28'd0, gnt1, gnt0, sel, busy}, 32'b0101);
        check("r0_c1_ops", {24'd0, add_a, add_b}, {24'd0, 4'd5, 4'd3});
        req0 = 1'b0;
        step();
        check("r0_c2", {28'd0, gnt0, done0, done1, busy}, 32'b1001);
        step();
        check("r0_c3_done", {28'd0, gnt0, done0, done1, busy}, 32'b1101);
        check("r0_c3_res", {27'd0, cout, result}, {27'd0, 1'b0, 4'd8});
        step();
        check("r0_c4_idle", {28'd0, gnt0, gnt1, done0, busy}, 32'd0);
        check("r0_c4_hold", {27'd0, cout, result}, {27'd0, 1'b0, 4'd8});

        // Single requester 1: 9 + 8 wraps with carry
        req1 = 1'b1; a1 = 4'd9; b1 = 4'd8;
        step();
        check("r1_c1_gnt", {28'd0, gnt1, gnt0, sel, busy}, 32'b1011);
        req1 = 1'b0;
        step();
        step();
        check("r1_c3_done", {29'd0, done1, done0, gnt1}, 32'b101);
        check("r1_c3_res", {27'd0, cout, result}, {27'd0, 1'b1, 4'd1});
        step();
        check("r1_c4_idle", {29'd0, gnt1, done1, busy}, 32'd0);

        // Reset wins over simultaneous requests, then both held together
        Reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
        a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd4;
        step();
        check("rst_vs_req", {28'd0, gnt1, gnt0, busy, result == 4'd0}, 32'b0001);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_w = k[0];
            step();
            check("rr_gnt", {29'd0, gnt1, gnt0, sel}, {29'd0, exp_w, ~exp_w, exp_w});
            step();
            check("rr_wait_done", {30'd0, done1, done0}, 32'd0);
            step();
            check("rr_done", {30'd0, done1, done0}, {30'd0, exp_w, ~exp_w});
            check("rr_result", {28'd0, result}, exp_w ? 32'd7 : 32'd3);
            step();
            check("rr_idle", {28'd0, gnt1, gnt0, done1, done0, busy} , 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Operand change during WAIT is ignored (last=1 so requester 0 served)
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd3;
        step();
        check("opchg_gnt", {30'd0, gnt0, sel}, 32'b10);
        a0 = 4'd15; req0 = 1'b0;
        step();
        check("opchg_hold", {28'd0, add_a}, 32'd5);
        step();
        check("opchg_res", {27'd0, cout, result}, {27'd0, 1'b0, 4'd8});
        step();

        // Reset in the second WAIT cycle aborts the transaction
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd3;
        step();
        req0 = 1'b0;
        step();
        check("abort_wait2", {30'd0, gnt0, busy}, 32'b11);
        Reset = 1'b1;
        step();
        check("abort_idle", {28'd0, busy, gnt0, done0, cout}, 32'd0);
        check("abort_result", {28'd0, result}, 32'd0);
        Reset = 1'b0;
        step();
        check("abort_nodone", {29'd0, done0, done1, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
